// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse front end: filters the PS/2 clock, deserialises 11-bit frames,
// checks framing/parity and assembles 3-byte stream packets into sign/magnitude movement.
module ps2_mouse_rx #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic       clk_50MHz,
    input  logic       vga_reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] mouse_x,
    output logic [7:0] mouse_y,
    output logic       mouse_x_sign,
    output logic       mouse_y_sign,
    output logic       mouse_l_click,
    output logic       mouse_r_click,
    output logic       mouse_valid,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_filt_q;
    logic [FW-1:0] filt_cnt_q;
    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [1:0]    pkt_idx_q;
    logic [7:0]    byte0_q, byte1_q;
    logic [WW-1:0] wd_q;
    logic [7:0]    x_q, y_q;
    logic          xs_q, ys_q, l_q, r_q, valid_q, err_q;

    logic          clk_s_c, dat_s_c, filt_done_c, strobe_c, busy_c, timeout_c;
    logic [8:0]    dx_c, dy_c;
    logic [7:0]    x_d, y_d;

    // Sign/magnitude with saturation; the overflow flag pins the magnitude at full scale.
    function automatic logic [7:0] sat_mag(input logic [8:0] d, input logic ovf);
        logic [8:0] m;
        m = d[8] ? 9'(-d) : d;
        return (ovf || m[8]) ? 8'hFF : m[7:0];
    endfunction

    always_comb begin
        clk_s_c     = clk_sync_q[1];
        dat_s_c     = dat_sync_q[1];
        filt_done_c = (clk_s_c != clk_filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
        strobe_c    = filt_done_c && clk_filt_q;
        busy_c      = (state_q != S_IDLE) || (pkt_idx_q != 2'd0);
        timeout_c   = !strobe_c && busy_c && (wd_q == WW'(TIMEOUT - 1));
        dx_c        = {byte0_q[4], byte1_q};
        dy_c        = {byte0_q[5], shift_q};
        x_d         = sat_mag(dx_c, byte0_q[6]);
        y_d         = sat_mag(dy_c, byte0_q[7]);
    end

    always_ff @(posedge clk_50MHz or negedge vga_reset) begin
        if (!vga_reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            pkt_idx_q  <= '0;
            byte0_q    <= '0;
            byte1_q    <= '0;
            wd_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            xs_q       <= 1'b0;
            ys_q       <= 1'b0;
            l_q        <= 1'b0;
            r_q        <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            valid_q    <= 1'b0;
            err_q      <= 1'b0;

            // Glitch filter: a new level must persist FILTER_LEN samples before it is taken.
            if (clk_s_c == clk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_done_c) begin
                clk_filt_q <= clk_s_c;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end

            if (strobe_c) begin
                wd_q <= '0;
                unique case (state_q)
                    S_IDLE: begin
                        if (!dat_s_c) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q   <= {dat_s_c, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        if (^{dat_s_c, shift_q}) begin
                            state_q <= S_STOP;
                        end else begin
                            state_q   <= S_IDLE;
                            pkt_idx_q <= '0;
                            err_q     <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (!dat_s_c) begin
                            pkt_idx_q <= '0;
                            err_q     <= 1'b1;
                        end else begin
                            unique case (pkt_idx_q)
                                2'd0: begin
                                    if (shift_q[3]) begin
                                        byte0_q   <= shift_q;
                                        pkt_idx_q <= 2'd1;
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                                2'd1: begin
                                    byte1_q   <= shift_q;
                                    pkt_idx_q <= 2'd2;
                                end
                                default: begin
                                    pkt_idx_q <= '0;
                                    x_q       <= x_d;
                                    y_q       <= y_d;
                                    xs_q      <= dx_c[8];
                                    ys_q      <= dy_c[8];
                                    l_q       <= byte0_q[0];
                                    r_q       <= byte0_q[1];
                                    valid_q   <= 1'b1;
                                end
                            endcase
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (timeout_c) begin
                state_q   <= S_IDLE;
                pkt_idx_q <= '0;
                err_q     <= 1'b1;
                wd_q      <= '0;
            end else if (busy_c) begin
                wd_q <= wd_q + WW'(1);
            end else begin
                wd_q <= '0;
            end
        end
    end

    assign mouse_x       = x_q;
    assign mouse_y       = y_q;
    assign mouse_x_sign  = xs_q;
    assign mouse_y_sign  = ys_q;
    assign mouse_l_click = l_q;
    assign mouse_r_click = r_q;
    assign mouse_valid   = valid_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: bit-bangs PS/2 frames and checks decoded packets and error strobes.
module tb_ps2_mouse_rx;

    localparam int unsigned TB_TIMEOUT = 2000;
    localparam int          HALF       = 20;
    localparam int          LAT        = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] mouse_x, mouse_y;
    logic       mouse_x_sign, mouse_y_sign, mouse_l_click, mouse_r_click, mouse_valid, frame_err;

    int checks = 0, errors = 0;
    int cyc = 0, fall_cyc = 0;
    int vcnt = 0, ecnt = 0, vcyc = 0, ecyc = 0, wide = 0, both = 0;
    int v0, e0;
    logic prev_valid = 1'b0;

    ps2_mouse_rx #(.FILTER_LEN(8), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk_50MHz(clk), .vga_reset(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_x_sign(mouse_x_sign),
        .mouse_y_sign(mouse_y_sign), .mouse_l_click(mouse_l_click),
        .mouse_r_click(mouse_r_click), .mouse_valid(mouse_valid), .frame_err(frame_err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mouse_valid) begin
            vcnt <= vcnt + 1;
            vcyc <= cyc;
            if (prev_valid) wide <= wide + 1;
            if (frame_err) both <= both + 1;
        end
        if (frame_err) begin
            ecnt <= ecnt + 1;
            ecyc <= cyc;
        end
        prev_valid <= mouse_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk) ps2_data = v;
        repeat (HALF / 2) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ bad_par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0, 1'b0);
        send_byte(b1, 1'b0, 1'b0);
        send_byte(b2, 1'b0, 1'b0);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] x, input logic [7:0] y,
                              input logic xs, input logic ys, input logic l, input logic r);
        check({tag, "_x"}, 32'(mouse_x), 32'(x));
        check({tag, "_y"}, 32'(mouse_y), 32'(y));
        check({tag, "_flags"}, 32'({mouse_x_sign, mouse_y_sign, mouse_l_click, mouse_r_click}),
              32'({xs, ys, l, r}));
    endtask

    // Sends a packet and checks one valid strobe at fixed latency plus decoded fields.
    task automatic pkt_expect(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] x, input logic [7:0] y,
                              input logic xs, input logic ys, input logic l, input logic r);
        int vb, eb;
        vb = vcnt;
        eb = ecnt;
        send_pkt(b0, b1, b2);
        check({tag, "_vcnt"}, 32'(vcnt), 32'(vb + 1));
        check({tag, "_lat"}, 32'(vcyc - fall_cyc), 32'(LAT));
        check({tag, "_ecnt"}, 32'(ecnt), 32'(eb));
        check_outs(tag, x, y, xs, ys, l, r);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check_outs("reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_strobes", 32'({mouse_valid, frame_err}), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        pkt_expect("p_09", 8'h09, 8'h05, 8'hFB, 8'd5, 8'd251, 1'b0, 1'b0, 1'b1, 1'b0);
        pkt_expect("p_29", 8'h29, 8'h05, 8'hFB, 8'd5, 8'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        pkt_expect("p_m256", 8'h18, 8'h00, 8'h00, 8'd255, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        pkt_expect("p_xovf", 8'h48, 8'h10, 8'h00, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pkt_expect("p_yovf", 8'hA8, 8'h00, 8'h02, 8'd0, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0);

        // Bad parity on the first byte, then a clean packet.
        v0 = vcnt; e0 = ecnt;
        send_byte(8'h09, 1'b1, 1'b0);
        check("badpar_err", 32'(ecnt), 32'(e0 + 1));
        check("badpar_noval", 32'(vcnt), 32'(v0));
        check_outs("badpar_hold", 8'd0, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0);
        pkt_expect("p_after_par", 8'h09, 8'h03, 8'h02, 8'd3, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);

        e0 = ecnt;
        send_byte(8'h09, 1'b0, 1'b1);
        check("badstop_err", 32'(ecnt), 32'(e0 + 1));

        // Missing sync bit drops the byte; the next packet still aligns.
        v0 = vcnt; e0 = ecnt;
        send_byte(8'h01, 1'b0, 1'b0);
        check("sync_err", 32'(ecnt), 32'(e0 + 1));
        check("sync_noval", 32'(vcnt), 32'(v0));
        pkt_expect("p_after_sync", 8'h0A, 8'h01, 8'h01, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Two bytes then silence: watchdog aborts the partial packet.
        v0 = vcnt; e0 = ecnt;
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        check("to_early", 32'(ecnt), 32'(e0));
        repeat (TB_TIMEOUT + 100) @(negedge clk);
        check("to_err", 32'(ecnt), 32'(e0 + 1));
        check("to_time", 32'(ecyc - fall_cyc), 32'(TB_TIMEOUT + LAT));
        check("to_noval", 32'(vcnt), 32'(v0));
        pkt_expect("p_after_to", 8'h09, 8'h07, 8'h00, 8'd7, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Short low glitch with data low must not start a frame.
        v0 = vcnt; e0 = ecnt;
        @(negedge clk) ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        ps2_data = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch_err", 32'(ecnt), 32'(e0));
        check("glitch_val", 32'(vcnt), 32'(v0));
        pkt_expect("p_after_glitch", 8'h0A, 8'h02, 8'hFE, 8'd2, 8'd254, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of byte 1.
        send_byte(8'h09, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("midrst", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_strobes", 32'({mouse_valid, frame_err}), 32'd0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        pkt_expect("p_after_rst", 8'h09, 8'h04, 8'h04, 8'd4, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0);

        check("valid_width", 32'(wide), 32'd0);
        check("valid_err_overlap", 32'(both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench time limit");
    end

endmodule
